// File: rtl/sfifo_mixed_pack.sv
// Single-clock FIFO that packs RATIO narrow words into one wide word and reads it out non-showahead.
// Optional partial-word flush is enabled with `define SFIFO_MIXED_PACK_FLUSH_EN.
module sfifo_mixed_pack #(
   parameter int unsigned WIDTH_IN   = 128,
   parameter int unsigned WIDTH_OUT  = 512,
   parameter int unsigned RATIO      = 4,
   parameter int unsigned LANE_WIDTH = 2,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  aclr_n,
   input  logic [WIDTH_IN-1:0]   data,
   input  logic                  wrreq,
   input  logic                  rdreq,
`ifdef SFIFO_MIXED_PACK_FLUSH_EN
   input  logic                  flush,
`endif
   output logic [WIDTH_OUT-1:0]  q,
   output logic                  rdempty,
   output logic                  wrfull,
   output logic [ADDR_WIDTH:0]   usedw,
   output logic [LANE_WIDTH-1:0] lane_cnt
);

   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]         FULL_CNT  = CW'(DEPTH);
   localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(RATIO - 1);

   logic [WIDTH_OUT-1:0]  asm_q;
   logic [WIDTH_OUT-1:0]  asm_next;
   logic [WIDTH_OUT-1:0]  push_word;
   logic [WIDTH_OUT-1:0]  mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  complete;
   logic                  push;

   // Status is decoded from current state only; no same-cycle look-ahead.
   assign wrfull   = (count == FULL_CNT) && (lane_cnt == LAST_LANE);
   assign rdempty  = (count == '0);
   assign usedw    = count;
   assign wr_ok    = wrreq && !wrfull;
   assign rd_ok    = rdreq && !rdempty;
   assign complete = wr_ok && (lane_cnt == LAST_LANE);

   // Assembly register with the incoming narrow word dropped into its lane.
   always_comb begin
      asm_next = asm_q;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (wr_ok && (lane_cnt == LANE_WIDTH'(i)))
            asm_next[i*WIDTH_IN +: WIDTH_IN] = data;
      end
   end

`ifdef SFIFO_MIXED_PACK_FLUSH_EN
   logic [LANE_WIDTH:0] fill;
   logic                flush_push;

   assign fill       = {1'b0, lane_cnt} + (LANE_WIDTH+1)'(wr_ok);
   assign flush_push = flush && (fill != '0) && (count != FULL_CNT);
   assign push       = complete || flush_push;

   // Lanes not yet written for this word are pushed as zero.
   always_comb begin
      push_word = asm_next;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if ((LANE_WIDTH+1)'(i) >= fill)
            push_word[i*WIDTH_IN +: WIDTH_IN] = '0;
      end
   end
`else
   assign push      = complete;
   assign push_word = asm_next;
`endif

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         asm_q    <= '0;
         lane_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         q        <= '0;
      end else begin
         if (wr_ok)
            asm_q <= asm_next;
         if (push) begin
            lane_cnt <= '0;
            wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
         end else if (wr_ok) begin
            lane_cnt <= lane_cnt + LANE_WIDTH'(1);
         end
         if (rd_ok) begin
            q      <= mem[rd_ptr];
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         case ({push, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_word;
   end

endmodule
